reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Sits directly downstream of the PLL-locked reset generator.
- Takes the board-level reset in active-low form and releases the design's reset domains in a fixed order: XADC interface first, then core measurement logic, then display/VGA logic.
- Release of the core is gated on the XADC finishing calibration, with a timeout fallback.
- Provides a single sequencing point so no downstream block leaves reset before its data source is alive.

Parameters:
- SYNC_STAGES, 2: depth of the reset-deassertion synchronizer; legal range ≥2.
- HOLD_CYCLES, 16: clock cycles reset is held after synchronized deassertion, before XADC release; legal range ≥1.
- READY_CYCLES, 4: consecutive cycles xadc_busy must be sampled low to count as ready; legal range ≥1.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for XADC ready; legal range > READY_CYCLES.
- STAGE_GAP, 8: cycles between successive domain releases; legal range ≥1.

Ports:
- clk, input, 1: system clock, rising-edge.
- reset_n, input, 1: asynchronous active-low reset; upstream drives it from the inverted locked-reset.
- xadc_busy, input, 1: high while the XADC is calibrating or converting.
- xadc_reset_out, output, 1: active-high reset for the XADC interface.
- core_reset_out, output, 1: active-high reset for the measurement/core logic.
- disp_reset_out, output, 1: active-high reset for the display logic.
- seq_done, output, 1: high once all domains are released.
- timeout_flag, output, 1: sticky; set if the XADC wait timed out.

Behaviour:
Decided interface:
- One clock; reset is asynchronous and active-low.
- Ports are named clk and reset_n.

Asynchronous reset:
- reset_n low, at any time and for any duration including sub-cycle glitches, immediately drives:
  - xadc_reset_out = core_reset_out = disp_reset_out = 1
  - seq_done = 0, timeout_flag = 0
- Synchronizer chain, all counters and state go to zero/RESET.

Deassertion timing:
- Define edge 1 as the first rising clk edge with reset_n high.
- A '1' is shifted through SYNC_STAGES flops; the synchronized release is high after edge SYNC_STAGES.

States:
- RESET: wait for the synchronized release, then go to HOLD.
- HOLD: count HOLD_CYCLES edges. On the last one, register xadc_reset_out <= 0 and go to WAIT_XADC. With defaults, xadc_reset_out falls at edge 18 (SYNC_STAGES + HOLD_CYCLES).
- WAIT_XADC: sample xadc_busy on every edge after entry.
  - A ready counter increments on low and clears on high.
  - Let E be the edge at which the counter reaches READY_CYCLES; go to GAP_CORE.
  - A timeout counter increments every edge in this state. If it reaches TIMEOUT_CYCLES first, set timeout_flag <= 1 at that edge; that edge becomes E.
  - If both conditions occur on the same edge, ready takes precedence and timeout_flag stays 0.
- GAP_CORE: core_reset_out <= 0 at edge E + STAGE_GAP, then go to GAP_DISP.
- GAP_DISP: at edge E + 2·STAGE_GAP, disp_reset_out <= 0 and seq_done <= 1; go to DONE.
- DONE: terminal state. Outputs stay constant until reset_n is asserted.

Rules:
- xadc_busy is ignored outside WAIT_XADC.
- timeout_flag is cleared only by reset_n.
- Ordering invariant, which must hold in every cycle:
  - disp_reset_out = 0 implies core_reset_out = 0.
  - core_reset_out = 0 implies xadc_reset_out = 0.
- All reset outputs assert asynchronously and deassert synchronously to clk rising edge.
- Counters are sized with $clog2 of their parameter (plus 1) and never wrap; they saturate or stop on state exit.
- Assertion of reset_n mid-sequence, in any state, aborts the sequence. A full restart from edge 1 follows the next deassertion.

Test Plan:
1. Nominal power-up, defaults: reset_n low 5 cycles, xadc_busy low throughout. Required:
   - all resets 1 while reset_n is low
   - xadc_reset_out falls at edge 18; E = 22
   - core_reset_out falls at edge 30
   - disp_reset_out falls and seq_done rises at edge 38
   - timeout_flag = 0
2. Calibration delay: xadc_busy high until after edge 40, low from edge 41. Required: E = 44, core release at edge 52, disp release and seq_done at edge 60.
3. Busy glitch: xadc_busy low at edges 19–21, high at 22, low from 23. Required: ready counter restarts, E = 26, core release at 34, disp release at 42.
4. Timeout: xadc_busy stuck high. Required:
   - timeout_flag = 1 at edge 1042 (18 + 1024)
   - core release at 1050, disp release and seq_done at 1058
   - timeout_flag remains 1 until reset_n is asserted
5. Mid-sequence abort: reset_n low for 3 cycles starting mid-cycle after edge 20. Required:
   - all three reset outputs go 1 and seq_done goes 0 asynchronously
   - after re-deassertion, xadc release again at relative edge 18
6. Post-DONE glitch: a 2 ns reset_n low pulse while in DONE. Required: all resets assert immediately, seq_done = 0, timeout_flag = 0, and the full sequence repeats with scenario-1 timing.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases the XADC, core and display reset domains in order.
// The XADC domain leaves reset first; the core waits until the XADC reports
// ready (or a timeout expires); the display follows a fixed gap later.
// Reset outputs assert asynchronously and deassert on a rising clk edge.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int READY_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STAGE_GAP      = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic xadc_busy,
  output logic xadc_reset_out,
  output logic core_reset_out,
  output logic disp_reset_out,
  output logic seq_done,
  output logic timeout_flag
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
  localparam int CNT_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam int RDY_W  = $clog2(READY_CYCLES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [RDY_W-1:0] RDY_MAX   = RDY_W'(READY_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    RESET,
    HOLD,
    WAIT_XADC,
    GAP_CORE,
    GAP_DISP,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_release;
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [RDY_W-1:0]       r_rdy_cnt, w_rdy_nxt, w_rdy_inc;
  logic [TO_W-1:0]        r_to_cnt, w_to_nxt, w_to_inc;
  logic                   r_xadc_rst, w_xadc_rst_nxt;
  logic                   r_core_rst, w_core_rst_nxt;
  logic                   r_disp_rst, w_disp_rst_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_timeout, w_timeout_nxt;

  // Shift a one through the synchronizer so release is clean relative to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_release = r_sync[SYNC_STAGES-1];

  // State, counters and registered reset outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RESET;
      r_cnt      <= '0;
      r_rdy_cnt  <= '0;
      r_to_cnt   <= '0;
      r_xadc_rst <= 1'b1;
      r_core_rst <= 1'b1;
      r_disp_rst <= 1'b1;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rdy_cnt  <= w_rdy_nxt;
      r_to_cnt   <= w_to_nxt;
      r_xadc_rst <= w_xadc_rst_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_disp_rst <= w_disp_rst_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign w_rdy_inc = xadc_busy ? '0 : (r_rdy_cnt + 1'b1);
  assign w_to_inc  = r_to_cnt + 1'b1;

  // Next-state logic. The first edge that sees the synchronized release is
  // already counted as a hold edge, so the XADC release lands at
  // SYNC_STAGES + HOLD_CYCLES edges after reset_n deasserts.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rdy_nxt      = r_rdy_cnt;
    w_to_nxt       = r_to_cnt;
    w_xadc_rst_nxt = r_xadc_rst;
    w_core_rst_nxt = r_core_rst;
    w_disp_rst_nxt = r_disp_rst;
    w_done_nxt     = r_done;
    w_timeout_nxt  = r_timeout;
    unique case (r_state)
      RESET: begin
        if (w_release) begin
          if (HOLD_LAST == '0) begin
            w_xadc_rst_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = WAIT_XADC;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_xadc_rst_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = WAIT_XADC;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_XADC: begin
        w_rdy_nxt = w_rdy_inc;
        w_to_nxt  = w_to_inc;
        if (w_rdy_inc == RDY_MAX) begin
          w_cnt_nxt   = '0;
          w_state_nxt = GAP_CORE;
        end else if (w_to_inc == TO_MAX) begin
          w_timeout_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = GAP_CORE;
        end
      end
      GAP_CORE: begin
        if (r_cnt == GAP_LAST) begin
          w_core_rst_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = GAP_DISP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP_DISP: begin
        if (r_cnt == GAP_LAST) begin
          w_disp_rst_nxt = 1'b0;
          w_done_nxt     = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = RESET;
      end
    endcase
  end

  assign xadc_reset_out = r_xadc_rst;
  assign core_reset_out = r_core_rst;
  assign disp_reset_out = r_disp_rst;
  assign seq_done       = r_done;
  assign timeout_flag   = r_timeout;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven check of the reset release sequence,
// plus hand-written abort and post-DONE glitch sequences.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic xadc_busy = 1'b0;
  logic xadc_reset_out, core_reset_out, disp_reset_out, seq_done, timeout_flag;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;
  int curScn = 0;

  // Expected output word is {xadc, core, disp, done, timeout}.
  typedef struct {
    int         scn;
    int         edgeNum;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  reset_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .xadc_busy      (xadc_busy),
    .xadc_reset_out (xadc_reset_out),
    .core_reset_out (core_reset_out),
    .disp_reset_out (disp_reset_out),
    .seq_done       (seq_done),
    .timeout_flag   (timeout_flag)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // xadc_busy level presented before a given edge, per scenario.
  function automatic logic busyAt(int scn, int e);
    case (scn)
      2:       return (e <= 40);
      3:       return (e == 22);
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {xadc_reset_out, core_reset_out, disp_reset_out, seq_done, timeout_flag};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (x,c,d,done,to) at edge %0d",
               name, act, exp, edgeNum);
    end
  endtask

  // Advance to the requested edge count, driving xadc_busy on each negedge.
  task automatic runToEdge(input int target);
    while (edgeNum < target) begin
      @(negedge clk);
      xadc_busy = busyAt(curScn, edgeNum + 1);
      @(posedge clk);
      edgeNum++;
    end
    #1;
  endtask

  // Hold reset_n low for 5 cycles, then release it mid-cycle.
  task automatic applyStimulus();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("in_reset_start", 5'b11100);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("in_reset_end", 5'b11100);
    #1;
    reset_n = 1'b1;
    edgeNum = 0;
  endtask

  // Ordering invariant sampled every cycle.
  always @(negedge clk) begin
    checks++;
    if ((!disp_reset_out && core_reset_out) || (!core_reset_out && xadc_reset_out)) begin
      errors++;
      $display("[TB] FAIL order_invariant: got x=%b c=%b d=%b, expected release order x->c->d",
               xadc_reset_out, core_reset_out, disp_reset_out);
    end
  end

  initial begin
    // Scenario 1: nominal
    vecs.push_back('{1,    2, 5'b11100, "s1_sync"});
    vecs.push_back('{1,   17, 5'b11100, "s1_x_hold"});
    vecs.push_back('{1,   18, 5'b01100, "s1_x_rel"});
    vecs.push_back('{1,   29, 5'b01100, "s1_c_hold"});
    vecs.push_back('{1,   30, 5'b00100, "s1_c_rel"});
    vecs.push_back('{1,   37, 5'b00100, "s1_d_hold"});
    vecs.push_back('{1,   38, 5'b00010, "s1_d_rel"});
    vecs.push_back('{1,   50, 5'b00010, "s1_done_stable"});
    // Scenario 2: calibration delay, E = 44
    vecs.push_back('{2,   18, 5'b01100, "s2_x_rel"});
    vecs.push_back('{2,   51, 5'b01100, "s2_c_hold"});
    vecs.push_back('{2,   52, 5'b00100, "s2_c_rel"});
    vecs.push_back('{2,   59, 5'b00100, "s2_d_hold"});
    vecs.push_back('{2,   60, 5'b00010, "s2_d_rel"});
    // Scenario 3: busy glitch, E = 26
    vecs.push_back('{3,   33, 5'b01100, "s3_c_hold"});
    vecs.push_back('{3,   34, 5'b00100, "s3_c_rel"});
    vecs.push_back('{3,   41, 5'b00100, "s3_d_hold"});
    vecs.push_back('{3,   42, 5'b00010, "s3_d_rel"});
    // Scenario 4: timeout
    vecs.push_back('{4,  500, 5'b01100, "s4_waiting"});
    vecs.push_back('{4, 1041, 5'b01100, "s4_pre_timeout"});
    vecs.push_back('{4, 1042, 5'b01101, "s4_timeout"});
    vecs.push_back('{4, 1049, 5'b01101, "s4_c_hold"});
    vecs.push_back('{4, 1050, 5'b00101, "s4_c_rel"});
    vecs.push_back('{4, 1057, 5'b00101, "s4_d_hold"});
    vecs.push_back('{4, 1058, 5'b00011, "s4_d_rel"});
    vecs.push_back('{4, 1100, 5'b00011, "s4_sticky"});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].scn != curScn) begin
        curScn = vecs[i].scn;
        applyStimulus();
      end
      runToEdge(vecs[i].edgeNum);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Scenario 6: 2 ns reset_n glitch while in DONE with timeout set
    curScn = 6;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("s6_glitch_async", 5'b11100);
    #1;
    reset_n = 1'b1;
    edgeNum = 0;
    runToEdge(17);
    checkOutput("s6_x_hold", 5'b11100);
    runToEdge(18);
    checkOutput("s6_x_rel", 5'b01100);
    runToEdge(29);
    checkOutput("s6_c_hold", 5'b01100);
    runToEdge(30);
    checkOutput("s6_c_rel", 5'b00100);
    runToEdge(38);
    checkOutput("s6_d_rel", 5'b00010);

    // Scenario 5: abort mid-sequence after edge 20
    curScn = 5;
    applyStimulus();
    runToEdge(20);
    checkOutput("s5_before_abort", 5'b01100);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_abort_async", 5'b11100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("s5_abort_held", 5'b11100);
    #1;
    reset_n = 1'b1;
    edgeNum = 0;
    runToEdge(17);
    checkOutput("s5_x_hold", 5'b11100);
    runToEdge(18);
    checkOutput("s5_x_rel", 5'b01100);
    runToEdge(30);
    checkOutput("s5_c_rel", 5'b00100);
    runToEdge(38);
    checkOutput("s5_d_rel", 5'b00010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
